// File: rtl/coeff_sequencer_pkg.sv
// Shared constants, FSM state type and coefficient field layout for coeff_sequencer.
package coeff_sequencer_pkg;

  localparam int unsigned NUM_SEG         = 16;
  localparam int unsigned COEFF_AW        = 9;
  localparam int unsigned DATA_AW         = 8;
  localparam int unsigned COEFF_W         = 9;
  localparam int unsigned COEFF_SIGN_BIT  = 8;
  localparam int unsigned COEFF_SHIFT_MSB = 7;
  localparam int unsigned COEFF_SHIFT_LSB = 0;
  localparam int unsigned SHIFT_W         = COEFF_SHIFT_MSB - COEFF_SHIFT_LSB + 1;

  typedef enum logic [2:0] {
    StIdle,
    StRjReq,
    StRjLat,
    StRun,
    StDrain,
    StSeg,
    StFin
  } state_e;

endpackage

// File: rtl/coeff_sequencer_decode.sv
// Splits a 9-bit coefficient word into its sign flag and shift amount.
module coeff_sequencer_decode
  import coeff_sequencer_pkg::*;
(
  input  logic [COEFF_W-1:0] i_coeff,
  output logic               o_sign,
  output logic [SHIFT_W-1:0] o_shift
);

  assign o_sign  = i_coeff[COEFF_SIGN_BIT];
  assign o_shift = i_coeff[COEFF_SHIFT_MSB:COEFF_SHIFT_LSB];

endmodule

// File: rtl/coeff_sequencer.sv
// Walks rj segments and coefficient terms to drive a shift/accumulate datapath.
// Optional feature: define COEFF_OVF_CHECK_EN to flag coefficient index overflow.
module coeff_sequencer #(
  parameter int unsigned NUM_SEG  = coeff_sequencer_pkg::NUM_SEG,
  parameter int unsigned COEFF_AW = coeff_sequencer_pkg::COEFF_AW,
  parameter int unsigned DATA_AW  = coeff_sequencer_pkg::DATA_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_AW-1:0]  n_ptr,
  output logic [3:0]          rj_rd_addr,
  input  logic [7:0]          rj_rd_data,
  output logic [COEFF_AW-1:0] coeff_rd_addr,
  input  logic [8:0]          coeff_rd_data,
  output logic [DATA_AW-1:0]  x_rd_addr,
  output logic                x_sign,
  output logic                x_valid,
  output logic                seg_done,
  output logic                busy,
  output logic                done,
  output logic                coeff_err
);
  import coeff_sequencer_pkg::*;

  state_e               r_state, w_state_d;
  logic [DATA_AW-1:0]   r_nptr;
  logic [3:0]           r_seg;
  logic [COEFF_AW-1:0]  r_k;
  logic [7:0]           r_rem;
  logic                 r_drain;
  logic                 r_iss;
  logic                 r_xvalid;
  logic [DATA_AW-1:0]   r_xaddr;
  logic                 r_xsign;
  logic                 w_issue;
  logic                 w_ovf_hit;
  logic                 w_ovf_run;
  logic                 w_sign;
  logic [SHIFT_W-1:0]   w_shift;

  coeff_sequencer_decode u_decode (
    .i_coeff (coeff_rd_data),
    .o_sign  (w_sign),
    .o_shift (w_shift)
  );

  always_comb begin
    w_state_d     = r_state;
    w_issue       = 1'b0;
    rj_rd_addr    = '0;
    coeff_rd_addr = '0;
    seg_done      = 1'b0;
    done          = 1'b0;
    busy          = (r_state != StIdle);
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRjReq;
      StRjReq: begin
        rj_rd_addr = r_seg;
        w_state_d  = StRjLat;
      end
      // After an overflow the remaining segments are skipped but still signalled.
      StRjLat: w_state_d = ((rj_rd_data == '0) || w_ovf_run) ? StSeg : StRun;
      StRun: begin
        w_issue = ~w_ovf_hit;
        if (w_issue) coeff_rd_addr = r_k;
        if ((r_rem == 8'd1) || w_ovf_hit) w_state_d = StDrain;
      end
      StDrain: if (r_drain) w_state_d = StSeg;
      StSeg: begin
        seg_done  = 1'b1;
        w_state_d = (r_seg == 4'(NUM_SEG - 1)) ? StFin : StRjReq;
      end
      StFin: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_nptr   <= '0;
      r_seg    <= '0;
      r_k      <= '0;
      r_rem    <= '0;
      r_drain  <= 1'b0;
      r_iss    <= 1'b0;
      r_xvalid <= 1'b0;
      r_xaddr  <= '0;
      r_xsign  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == StIdle) && start) begin
        r_nptr <= n_ptr;
        r_seg  <= '0;
        r_k    <= '0;
      end
      if (r_state == StRjLat) r_rem <= rj_rd_data;
      if (w_issue) begin
        r_k   <= r_k + 1'b1;
        r_rem <= r_rem - 8'd1;
      end
      if (r_state == StDrain) r_drain <= ~r_drain;
      if (r_state == StSeg) r_seg <= r_seg + 4'd1;
      r_iss    <= w_issue;
      r_xvalid <= r_iss;
      if (r_iss) begin
        r_xaddr <= r_nptr - DATA_AW'(w_shift);
        r_xsign <= w_sign;
      end
    end
  end

  assign x_rd_addr = r_xaddr;
  assign x_sign    = r_xsign;
  assign x_valid   = r_xvalid;

`ifdef COEFF_OVF_CHECK_EN
  logic r_wrap;
  logic r_ovf;
  logic r_err;

  assign w_ovf_hit = (r_state == StRun) && r_wrap;
  assign w_ovf_run = r_ovf;
  assign coeff_err = r_err;

  // r_wrap/r_ovf are per sample; r_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == StIdle) && start) begin
        r_wrap <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_issue && (&r_k)) r_wrap <= 1'b1;
        if (w_ovf_hit) r_ovf <= 1'b1;
      end
      if (w_ovf_hit) r_err <= 1'b1;
    end
  end
`else
  assign w_ovf_hit = 1'b0;
  assign w_ovf_run = 1'b0;
  assign coeff_err = 1'b0;
`endif

endmodule

// File: tb/tb_coeff_sequencer.sv
// Directed self-checking bench for coeff_sequencer with behavioural rj/coeff memories.
module tb_coeff_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n_ptr = '0;
  logic [3:0] rj_rd_addr;
  logic [7:0] rj_rd_data = '0;
  logic [8:0] coeff_rd_addr;
  logic [8:0] coeff_rd_data = '0;
  logic [7:0] x_rd_addr;
  logic       x_sign, x_valid, seg_done, busy, done, coeff_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rj_mem   [16];
  logic [8:0] coeff_mem[512];

  // Observation records, appended at every falling edge.
  logic [7:0] xa_q[$];
  logic       xs_q[$];
  logic [8:0] ca_q[$];
  int         xv_cyc_q[$];
  int         sd_cyc_q[$];
  int         sd_xv_q[$];
  int         n_done = 0;
  int         cyc = 0;
  logic [8:0] ca_h1 = '0, ca_h2 = '0;

  coeff_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .n_ptr         (n_ptr),
    .rj_rd_addr    (rj_rd_addr),
    .rj_rd_data    (rj_rd_data),
    .coeff_rd_addr (coeff_rd_addr),
    .coeff_rd_data (coeff_rd_data),
    .x_rd_addr     (x_rd_addr),
    .x_sign        (x_sign),
    .x_valid       (x_valid),
    .seg_done      (seg_done),
    .busy          (busy),
    .done          (done),
    .coeff_err     (coeff_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rj_rd_data    <= rj_mem[rj_rd_addr];
    coeff_rd_data <= coeff_mem[coeff_rd_addr];
  end

  always @(negedge clk) begin
    if (x_valid) begin
      xa_q.push_back(x_rd_addr);
      xs_q.push_back(x_sign);
      ca_q.push_back(ca_h2);
      xv_cyc_q.push_back(cyc);
    end
    if (seg_done) begin
      sd_cyc_q.push_back(cyc);
      sd_xv_q.push_back(xa_q.size());
    end
    if (done) n_done <= n_done + 1;
    ca_h2 <= ca_h1;
    ca_h1 <= coeff_rd_addr;
    cyc   <= cyc + 1;
  end

  task automatic run_sample(input logic [7:0] np, input int budget, input string name);
    int d0;
    int cnt;
    d0 = n_done;
    cnt = 0;
    @(posedge clk); #1;
    n_ptr = np;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while ((n_done == d0) && (cnt < budget)) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (n_done == d0) $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, x_valid, seg_done, coeff_err} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy, done, x_valid, seg_done, coeff_err});
    else n_pass++;
    n_checks++;
    if (coeff_rd_addr !== 9'h0) $display("FAIL reset_caddr: got %h want 000", coeff_rd_addr);
    else n_pass++;
    n_checks++;
    if (rj_rd_addr !== 4'h0) $display("FAIL reset_rjaddr: got %h want 0", rj_rd_addr);
    else n_pass++;
    n_checks++;
    if (x_rd_addr !== 8'h0) $display("FAIL reset_xaddr: got %h want 00", x_rd_addr);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int b, s0, d0;
    for (int i = 0; i < 16; i++) rj_mem[i] = 8'd0;
    rj_mem[0]    = 8'd2;
    coeff_mem[0] = 9'h003;
    coeff_mem[1] = 9'h105;
    b = xa_q.size(); s0 = sd_cyc_q.size(); d0 = n_done;
    run_sample(8'h10, 200, "basic");
    n_checks++;
    if (xa_q.size() - b != 2) $display("FAIL basic_count: got %0d want 2", xa_q.size() - b);
    else n_pass++;
    n_checks++;
    if ({xa_q[b], xs_q[b]} !== {8'h0D, 1'b0})
      $display("FAIL basic_term0: got %h/%b want 0d/0", xa_q[b], xs_q[b]);
    else n_pass++;
    n_checks++;
    if ({xa_q[b+1], xs_q[b+1]} !== {8'h0B, 1'b1})
      $display("FAIL basic_term1: got %h/%b want 0b/1", xa_q[b+1], xs_q[b+1]);
    else n_pass++;
    n_checks++;
    if ({ca_q[b], ca_q[b+1]} !== {9'd0, 9'd1})
      $display("FAIL basic_caddr: got %0d,%0d want 0,1", ca_q[b], ca_q[b+1]);
    else n_pass++;
    n_checks++;
    if (sd_cyc_q[s0] != xv_cyc_q[b+1] + 1)
      $display("FAIL basic_segdone_lat: got cycle %0d want %0d", sd_cyc_q[s0], xv_cyc_q[b+1] + 1);
    else n_pass++;
    n_checks++;
    if (sd_cyc_q.size() - s0 != 16)
      $display("FAIL basic_segcount: got %0d want 16", sd_cyc_q.size() - s0);
    else n_pass++;
    n_checks++;
    if (n_done - d0 != 1) $display("FAIL basic_done: got %0d want 1", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_all_ones();
    int b, s0, d0;
    for (int i = 0; i < 16; i++) begin
      rj_mem[i]    = 8'd1;
      coeff_mem[i] = 9'(i);
    end
    b = xa_q.size(); s0 = sd_cyc_q.size(); d0 = n_done;
    run_sample(8'h40, 400, "ones");
    n_checks++;
    if (xa_q.size() - b != 16) $display("FAIL ones_count: got %0d want 16", xa_q.size() - b);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ca_q[b+i] !== 9'(i) || xa_q[b+i] !== 8'(8'h40 - i) || xs_q[b+i] !== 1'b0)
        $display("FAIL ones_term%0d: got caddr %0d xaddr %h sign %b want %0d %h 0",
                 i, ca_q[b+i], xa_q[b+i], xs_q[b+i], i, 8'(8'h40 - i));
      else n_pass++;
      n_checks++;
      if (sd_cyc_q[s0+i] != xv_cyc_q[b+i] + 1)
        $display("FAIL ones_seglat%0d: got cycle %0d want %0d", i, sd_cyc_q[s0+i],
                 xv_cyc_q[b+i] + 1);
      else n_pass++;
    end
    n_checks++;
    if (sd_cyc_q.size() - s0 != 16)
      $display("FAIL ones_segcount: got %0d want 16", sd_cyc_q.size() - s0);
    else n_pass++;
    n_checks++;
    if (n_done - d0 != 1) $display("FAIL ones_done: got %0d want 1", n_done - d0);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ones_busy_after: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_rj_zero();
    int b, s0;
    for (int i = 0; i < 16; i++) rj_mem[i] = 8'd1;
    rj_mem[3] = 8'd0;
    b = xa_q.size(); s0 = sd_cyc_q.size();
    run_sample(8'h80, 400, "rjzero");
    n_checks++;
    if (xa_q.size() - b != 15) $display("FAIL rjzero_count: got %0d want 15", xa_q.size() - b);
    else n_pass++;
    n_checks++;
    if (sd_xv_q[s0+3] - sd_xv_q[s0+2] != 0)
      $display("FAIL rjzero_seg3: got %0d terms want 0", sd_xv_q[s0+3] - sd_xv_q[s0+2]);
    else n_pass++;
    n_checks++;
    if (sd_cyc_q.size() - s0 != 16)
      $display("FAIL rjzero_segcount: got %0d want 16", sd_cyc_q.size() - s0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int b;
    for (int i = 0; i < 16; i++) rj_mem[i] = 8'd0;
    rj_mem[0]    = 8'd1;
    coeff_mem[0] = 9'h005;
    b = xa_q.size();
    run_sample(8'h02, 200, "wrap");
    n_checks++;
    if (xa_q.size() - b != 1 || xa_q[b] !== 8'hFD)
      $display("FAIL wrap_xaddr: got %h (count %0d) want fd (count 1)", xa_q[b], xa_q.size() - b);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt, b, s0, d0;
    for (int i = 0; i < 16; i++) begin
      rj_mem[i]    = 8'd1;
      coeff_mem[i] = 9'(i);
    end
    @(posedge clk); #1;
    n_ptr = 8'h20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while ((coeff_rd_addr !== 9'd5) && (cnt < 200)) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (coeff_rd_addr !== 9'd5) $display("FAIL midreset_reach: segment 5 never issued");
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    b = xa_q.size(); s0 = sd_cyc_q.size(); d0 = n_done;
    n_checks++;
    if ({busy, done, x_valid, seg_done} !== 4'b0)
      $display("FAIL midreset_flags: got %b want 0000", {busy, done, x_valid, seg_done});
    else n_pass++;
    n_checks++;
    if ({coeff_rd_addr, rj_rd_addr, x_rd_addr} !== '0)
      $display("FAIL midreset_addrs: got %h %h %h want 0 0 0", coeff_rd_addr, rj_rd_addr,
               x_rd_addr);
    else n_pass++;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (xa_q.size() != b || sd_cyc_q.size() != s0 || n_done != d0)
      $display("FAIL midreset_quiet: got %0d/%0d/%0d events want 0/0/0", xa_q.size() - b,
               sd_cyc_q.size() - s0, n_done - d0);
    else n_pass++;
    run_sample(8'h20, 400, "restart");
    n_checks++;
    if (xa_q.size() - b != 16 || ca_q[b] !== 9'd0)
      $display("FAIL restart_first: got count %0d caddr %0d want 16 0", xa_q.size() - b, ca_q[b]);
    else n_pass++;
  endtask

  task automatic test_long();
    int b, d0;
    for (int i = 0; i < 15; i++) rj_mem[i] = 8'd32;
    rj_mem[15] = 8'd40;
    for (int i = 0; i < 512; i++) coeff_mem[i] = {1'b0, 8'(i)};
    b = xa_q.size(); d0 = n_done;
    run_sample(8'h00, 1500, "long");
    n_checks++;
    if (xa_q.size() - b != 520) $display("FAIL long_count: got %0d want 520", xa_q.size() - b);
    else n_pass++;
    n_checks++;
    if (ca_q[b+511] !== 9'd511 || ca_q[b+512] !== 9'd0 || ca_q[b+519] !== 9'd7)
      $display("FAIL long_kwrap: got %0d,%0d,%0d want 511,0,7", ca_q[b+511], ca_q[b+512],
               ca_q[b+519]);
    else n_pass++;
    n_checks++;
    if (xa_q[b+300] !== 8'hD4) $display("FAIL long_xaddr300: got %h want d4", xa_q[b+300]);
    else n_pass++;
    n_checks++;
    if (coeff_err !== 1'b0 || n_done - d0 != 1)
      $display("FAIL long_err_done: got err %b done %0d want 0 1", coeff_err, n_done - d0);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rj_mem[i] = '0;
    for (int i = 0; i < 512; i++) coeff_mem[i] = '0;
    test_reset();
    test_basic();
    test_all_ones();
    test_rj_zero();
    test_wrap();
    test_reset_mid();
    test_long();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coeff_sequencer.md
COEFF_SEQUENCER -- requirements
Module: coeff_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: NUM_SEG, 16, number of rj segments per output sample.
REQ-002 COEFF_AW, 9, coefficient memory address width (512 entries).
REQ-003 DATA_AW, 8, circular data memory address width (256 samples).
REQ-004 Ports SHALL be, one per line: clk  in  1  single system clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to compute one output sample.
REQ-007 n_ptr  in  DATA_AW  data memory index of the newest sample.
REQ-008 rj_rd_addr  out  4  rj memory read address (segment index).
REQ-009 rj_rd_data  in  8  term count of the addressed segment; valid one cycle after address.
REQ-010 coeff_rd_addr  out  COEFF_AW  coefficient memory read address.
REQ-011 coeff_rd_data  in  9  coefficient {sign, shift[7:0]}; valid one cycle after address.
REQ-012 x_rd_addr  out  DATA_AW  data memory address of the term to accumulate.
REQ-013 x_sign  out  1  1 = subtract term, 0 = add term.
REQ-014 x_valid  out  1  datapath SHALL accumulate the term this cycle.
REQ-015 seg_done  out  1  pulse; datapath SHALL perform y = (y + u) >> 1 and clear u.
REQ-016 busy  out  1  high from the cycle after an accepted start until done.
REQ-017 done  out  1  one-cycle pulse; sample complete.
REQ-018 coeff_err  out  1  sticky overflow flag (COEFF_OVF_CHECK_EN only, else tied 0).

Function
REQ-019 FSM states SHALL be IDLE, RJ_REQ, RJ_LAT, RUN, DRAIN, SEG, FIN.
REQ-020 IDLE: start=1 -> latch n_ptr, clear seg and k to 0, go to RJ_REQ; start while busy is ignored.
REQ-021 RJ_REQ drives rj_rd_addr=seg; RJ_LAT latches rj_rd_data into remaining; remaining=0 -> SEG, else -> RUN.
REQ-022 RUN issues coeff_rd_addr=k for exactly one cycle per term, k increments, remaining decrements; remaining reaching 0 -> DRAIN.
REQ-023 k SHALL be global across segments (segment j starts at the sum of previous rj) and SHALL reset to 0 only on start or reset.
REQ-024 Term pipeline: x_rd_addr = latched n_ptr - coeff_rd_data[7:0] modulo 2^DATA_AW, x_sign = coeff_rd_data[8], registered; x_valid asserts 2 cycles after the matching coeff_rd_addr issue.
REQ-025 DRAIN SHALL hold 2 cycles so seg_done pulses in SEG exactly 1 cycle after the segment's last x_valid.
REQ-026 SEG pulses seg_done, increments seg; seg = NUM_SEG-1 -> FIN, else -> RJ_REQ.
REQ-027 FIN pulses done and returns to IDLE; start is accepted again in the next cycle.
REQ-028 rj = 0 SHALL produce a seg_done with no x_valid for that segment.
REQ-029 Without the check macro, k SHALL wrap 511 -> 0 silently.

Reset
REQ-030 reset SHALL force IDLE and zero all outputs, seg, k, remaining and pipeline valids on the next edge, including mid-run; no x_valid, seg_done or done after reset.
REQ-031 coeff_err SHALL clear only on reset.

Configuration
REQ-032 With COEFF_OVF_CHECK_EN defined, issuing a term while k = 511 has already been issued SHALL set coeff_err, suppress further x_valid, and proceed to FIN with remaining seg_done pulses.
REQ-033 Without COEFF_OVF_CHECK_EN, coeff_err SHALL be constant 0 and k wraps per REQ-029.

Structure
REQ-034 Shared package SHALL hold NUM_SEG, COEFF_AW, DATA_AW, the state enumeration and the coefficient field positions (sign bit 8, shift 7:0).
REQ-035 The 9-bit coefficient decode (sign/shift split) SHALL be reused as the existing decode sub-module; no other sub-module.

Verification
REQ-036 n_ptr=0x10, rj0=2, coeff[0]=0x003, coeff[1]=0x105 -> x_valid twice: (0x0D, sign 0), (0x0B, sign 1); seg_done 1 cycle later.
REQ-037 All rj=1, coeff[i]=i -> 16 x_valid, coeff_rd_addr 0..15 in order, 16 seg_done, one done, busy low after done.
REQ-038 rj3=0, others 1 -> segment 3 yields seg_done with no x_valid; total x_valid = 15.
REQ-039 n_ptr=0x02, coeff=0x005 -> x_rd_addr=0xFD (wrap).
REQ-040 reset asserted during RUN of segment 5 -> next cycle IDLE, all outputs 0; new start restarts at coeff_rd_addr 0.
REQ-041 rj sum = 520 -> with COEFF_OVF_CHECK_EN: coeff_err=1, exactly 512 x_valid, done asserted; without: coeff_rd_addr wraps to 0, 520 x_valid.
